// File: rtl/tse_txfifo_wr_sched_pkg.sv
// rtl/tse_txfifo_wr_sched_pkg.sv - shared types and constants for the TX FIFO write scheduler
package tse_txsched_pkg;

  // Scheduler states: arbitrate, wait for FIFO space, move words, discard an oversize tail.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bit positions inside err_pulse.
  localparam int ERR_NO_SOF   = 0;
  localparam int ERR_PROTO    = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_W        = 3;

  // Free words that must remain before another word is accepted; covers the
  // output register plus the lag of the registered free count.
  localparam int FREE_MARGIN = 2;

endpackage

// File: rtl/tse_txfifo_wr_sched_if.sv
// rtl/tse_txfifo_wr_sched_if.sv - requester and FIFO write-port interfaces
interface tse_txsched_req_if #(
  parameter int DATA_W = 32,
  parameter int MOD_W  = $clog2(DATA_W/8)
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              sof;
  logic              eof;
  logic [MOD_W-1:0]  mod;
  logic              abort;
  logic              ready;

  // Frame source side.
  modport master (output valid, data, sof, eof, mod, abort, input ready);
  // Scheduler side.
  modport slave  (input valid, data, sof, eof, mod, abort, output ready);
endinterface

interface tse_txsched_fifo_if #(
  parameter int DATA_W = 32,
  parameter int MOD_W  = $clog2(DATA_W/8),
  parameter int TABITS = 12
);
  logic              wr;
  logic [DATA_W-1:0] data;
  logic              sof;
  logic              eof;
  logic [MOD_W-1:0]  mod;
  logic              abort;
  logic [TABITS:0]   free;

  // Scheduler side: drives the write port, observes free space.
  modport master (output wr, data, sof, eof, mod, abort, input free);
  // FIFO pointer-logic side.
  modport slave  (input wr, data, sof, eof, mod, abort, output free);
endinterface

// File: rtl/tse_txfifo_wr_sched_arb.sv
// rtl/tse_txfifo_wr_sched_arb.sv - two-input round-robin arbiter
module tse_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/tse_txfifo_wr_sched.sv
// rtl/tse_txfifo_wr_sched.sv - frame-boundary write scheduler for the TSE transmit FIFO
module tse_txfifo_wr_sched
  import tse_txsched_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MOD_W         = $clog2(DATA_W/8),
  parameter int TABITS        = 12,
  parameter int MAX_FRM_WORDS = 512,
  parameter int CNT_W         = $clog2(MAX_FRM_WORDS+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tse_txsched_req_if.slave       req0,
  tse_txsched_req_if.slave       req1,
  tse_txsched_fifo_if.master     fifo,
  input  logic [TABITS:0]        start_thresh_i,
  output logic [1:0]             grant_o,
  output logic [15:0]            frm_cnt_o,
  output logic [ERR_W-1:0]       err_pulse_o
);

  localparam int                FREE_W   = TABITS + 1;
  localparam logic [FREE_W-1:0] MARGIN   = FREE_W'(FREE_MARGIN);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_FRM_WORDS);

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [15:0]         frm_cnt_q, frm_cnt_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                abort_q, abort_d;
  logic [ERR_W-1:0]    err_q, err_d;

  logic [1:0]          cand;
  logic [1:0]          arb_grant;
  logic [1:0]          idle_rdy;
  logic                own_ready;

  logic                own_valid;
  logic [DATA_W-1:0]   own_data;
  logic                own_sof;
  logic                own_eof;
  logic [MOD_W-1:0]    own_mod;
  logic                own_abort;

  // Only frame starts compete for the write port.
  assign cand = {req1.valid & req1.sof, req0.valid & req0.sof};

  tse_rr_arb2 u_arb (
    .req_i        (cand),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

  // Owner view of the granted requester; grant_q is one-hot outside IDLE.
  assign own_valid = grant_q[1] ? req1.valid : req0.valid;
  assign own_data  = grant_q[1] ? req1.data  : req0.data;
  assign own_sof   = grant_q[1] ? req1.sof   : req0.sof;
  assign own_eof   = grant_q[1] ? req1.eof   : req0.eof;
  assign own_mod   = grant_q[1] ? req1.mod   : req0.mod;
  assign own_abort = grant_q[1] ? req1.abort : req0.abort;

  // Next-state, handshake and registered-output decode for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    frm_cnt_d    = frm_cnt_q;
    wr_d         = 1'b0;
    data_d       = data_q;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    mod_d        = '0;
    abort_d      = 1'b0;
    err_d        = '0;
    idle_rdy     = 2'b00;
    own_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        // Mid-frame words arriving with no frame open are swallowed and flagged.
        if (req0.valid && !req0.sof) begin
          idle_rdy[0]        = 1'b1;
          err_d[ERR_NO_SOF]  = 1'b1;
        end
        if (req1.valid && !req1.sof) begin
          idle_rdy[1]        = 1'b1;
          err_d[ERR_NO_SOF]  = 1'b1;
        end
        if (|cand) begin
          grant_d = arb_grant;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (own_abort) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (fifo.free >= start_thresh_i) begin
          state_d = XFER;
        end
      end

      XFER: begin
        if (own_abort) begin
          abort_d = 1'b1;
          wcnt_d  = '0;
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (wcnt_q == MAX_CNT) begin
          // The frame filled its budget without an eof; rewind and drop the tail.
          abort_d             = 1'b1;
          err_d[ERR_OVERSIZE] = 1'b1;
          wcnt_d              = '0;
          state_d             = DRAIN;
        end else if (own_valid && own_sof && (wcnt_q != '0)) begin
          // A new frame started before eof: leave the word with its source.
          abort_d          = 1'b1;
          err_d[ERR_PROTO] = 1'b1;
          wcnt_d           = '0;
          grant_d          = 2'b00;
          state_d          = IDLE;
        end else begin
          own_ready = (fifo.free > MARGIN);
          if (own_valid && own_ready) begin
            wr_d   = 1'b1;
            data_d = own_data;
            sof_d  = (wcnt_q == '0);
            wcnt_d = wcnt_q + CNT_W'(1);
            if (own_eof) begin
              eof_d        = 1'b1;
              mod_d        = own_mod;
              frm_cnt_d    = frm_cnt_q + 16'd1;
              last_grant_d = grant_q[1];
              wcnt_d       = '0;
              grant_d      = 2'b00;
              state_d      = IDLE;
            end
          end
        end
      end

      DRAIN: begin
        own_ready = 1'b1;
        if (own_abort || (own_valid && own_eof)) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign req0.ready = idle_rdy[0] | (own_ready & grant_q[0]);
  assign req1.ready = idle_rdy[1] | (own_ready & grant_q[1]);

  // State and output registers; reset leaves the FIFO alone (no rewind pulse).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      wcnt_q       <= '0;
      frm_cnt_q    <= '0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      mod_q        <= '0;
      abort_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
      frm_cnt_q    <= frm_cnt_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      mod_q        <= mod_d;
      abort_q      <= abort_d;
      err_q        <= err_d;
    end
  end

  assign fifo.wr     = wr_q;
  assign fifo.data   = data_q;
  assign fifo.sof    = sof_q;
  assign fifo.eof    = eof_q;
  assign fifo.mod    = mod_q;
  assign fifo.abort  = abort_q;
  assign grant_o     = grant_q;
  assign frm_cnt_o   = frm_cnt_q;
  assign err_pulse_o = err_q;

endmodule

// File: tb/tb_tse_txfifo_wr_sched.sv
// tb/tb_tse_txfifo_wr_sched.sv - scoreboard bench for the TX FIFO write scheduler
module tb_tse_txfifo_wr_sched;

  localparam int MAXW  = 8;
  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] start_thresh;
  logic [1:0]  grant;
  logic [15:0] frm_cnt;
  logic [2:0]  err_pulse;

  always #5 clk = ~clk;

  tse_txsched_req_if  #(.DATA_W(32), .MOD_W(2))               req0_if ();
  tse_txsched_req_if  #(.DATA_W(32), .MOD_W(2))               req1_if ();
  tse_txsched_fifo_if #(.DATA_W(32), .MOD_W(2), .TABITS(12))  fifo_if ();

  tse_txfifo_wr_sched #(
    .DATA_W(32), .MOD_W(2), .TABITS(12), .MAX_FRM_WORDS(MAXW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req0           (req0_if),
    .req1           (req1_if),
    .fifo           (fifo_if),
    .start_thresh_i (start_thresh),
    .grant_o        (grant),
    .frm_cnt_o      (frm_cnt),
    .err_pulse_o    (err_pulse)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [3:0]  sof_ids[$];
  logic [35:0] mon_e;
  int          n_abort = 0;
  int          n_err[3] = '{0, 0, 0};
  int          exp_abort = 0;
  int          exp_err[3] = '{0, 0, 0};
  int          exp_frm = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int r, input int f, input int i);
    logic [3:0]  rr = r[3:0];
    logic [3:0]  ff = f[3:0];
    logic [7:0]  mid = 8'(f * 37 + r * 11);
    logic [15:0] ii = i[15:0];
    return {rr, ff, mid, ii};
  endfunction

  task automatic set_req(input int r, input logic v, input logic [31:0] d,
                         input logic s, input logic e, input logic [1:0] m);
    if (r == 0) begin
      req0_if.valid = v; req0_if.data = d; req0_if.sof = s; req0_if.eof = e; req0_if.mod = m;
    end else begin
      req1_if.valid = v; req1_if.data = d; req1_if.sof = s; req1_if.eof = e; req1_if.mod = m;
    end
  endtask

  task automatic set_abort(input int r, input logic a);
    if (r == 0) req0_if.abort = a;
    else        req1_if.abort = a;
  endtask

  function automatic logic get_ready(input int r);
    return (r == 0) ? req0_if.ready : req1_if.ready;
  endfunction

  // Presents one word and waits (bounded) for the handshake; returns at posedge+1.
  task automatic put_word(input int r, input logic [31:0] d, input logic s, input logic e,
                          input logic [1:0] m, output bit ok, output int waited);
    set_req(r, 1'b1, d, s, e, m);
    ok = 1'b0;
    waited = 0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      waited = c + 1;
      if (get_ready(r)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    set_req(r, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    check_eq("accept", ok, 1);
  endtask

  task automatic put_exp(input int r, input logic [31:0] d, input logic s, input logic e,
                         input logic [1:0] m);
    bit ok;
    int w;
    put_word(r, d, s, e, m, ok, w);
    if (ok) exp_q.push_back({d, s, e, e ? m : 2'd0});
  endtask

  // Words past MAXW are expected to be consumed without being written.
  task automatic send_frame(input int r, input int f, input int n, input logic [1:0] m);
    bit ok;
    int w;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = mk_data(r, f, i);
      put_word(r, d, i == 0, i == n - 1, (i == n - 1) ? m : 2'd0, ok, w);
      if (ok && i < MAXW) exp_q.push_back({d, i == 0, i == n - 1, (i == n - 1) ? m : 2'd0});
    end
    if (n <= MAXW) exp_frm++;
    else begin
      exp_abort++;
      exp_err[2]++;
    end
  endtask

  // Output monitor: scoreboard pop on every write, pulse counters.
  always @(negedge clk) begin
    if (fifo_if.abort) begin
      n_abort++;
      check_eq("wr_abort_excl", fifo_if.wr, 0);
    end
    for (int b = 0; b < 3; b++) if (err_pulse[b]) n_err[b]++;
    if (fifo_if.wr) begin
      check_eq("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("sb_word", {fifo_if.data, fifo_if.sof, fifo_if.eof, fifo_if.mod}, mon_e);
      end
      if (fifo_if.sof) sof_ids.push_back(fifo_if.data[31:28]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int w;
    int exp_ids[4] = '{0, 1, 0, 1};

    set_req(0, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    set_req(1, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    set_abort(0, 1'b0);
    set_abort(1, 1'b0);
    fifo_if.free = 13'd100;
    start_thresh = 13'd16;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_wr", fifo_if.wr, 0);
    check_eq("rst_abort", fifo_if.abort, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_frm_cnt", frm_cnt, 0);
    check_eq("rst_err", err_pulse, 0);
    check_eq("rst_ready", {req1_if.ready, req0_if.ready}, 0);
    @(posedge clk); #1;

    // Single 4-word frame from requester 1
    put_exp(1, mk_data(1, 0, 0), 1'b1, 1'b0, 2'd0);
    check_eq("t1_grant", grant, 2'b10);
    put_exp(1, mk_data(1, 0, 1), 1'b0, 1'b0, 2'd0);
    put_exp(1, mk_data(1, 0, 2), 1'b0, 1'b0, 2'd0);
    put_exp(1, mk_data(1, 0, 3), 1'b0, 1'b1, 2'd3);
    exp_frm++;
    @(negedge clk);
    check_eq("t1_frm_cnt", frm_cnt, exp_frm);
    check_eq("t1_grant_idle", grant, 0);
    @(posedge clk); #1;

    // Stray non-sof word in IDLE is discarded
    set_req(1, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check_eq("t1b_discard_ready", req1_if.ready, 1);
    exp_err[0]++;
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    check_eq("t1b_err0", n_err[0], exp_err[0]);
    @(posedge clk); #1;

    // Simultaneous starts after reset alternate, requester 0 first
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_frm = 0;
    sof_ids.delete();
    fork
      begin
        send_frame(0, 1, 3, 2'd1);
        send_frame(0, 2, 2, 2'd0);
      end
      begin
        send_frame(1, 1, 2, 2'd2);
        send_frame(1, 2, 3, 2'd3);
      end
    join
    repeat (3) @(negedge clk);
    check_eq("t2_nframes", sof_ids.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sof_ids.size()) check_eq("t2_order", sof_ids[i], exp_ids[i]);
    check_eq("t2_frm_cnt", frm_cnt, exp_frm);
    @(posedge clk); #1;

    // Start threshold gating and mid-frame space stall
    fifo_if.free = 13'd10;
    set_req(0, 1'b1, mk_data(0, 3, 0), 1'b1, 1'b0, 2'd0);
    repeat (4) @(negedge clk);
    check_eq("t3_wait_ready", req0_if.ready, 0);
    check_eq("t3_wait_grant", grant, 2'b01);
    @(posedge clk); #1;
    fifo_if.free = 13'd16;
    put_word(0, mk_data(0, 3, 0), 1'b1, 1'b0, 2'd0, ok, w);
    if (ok) exp_q.push_back({mk_data(0, 3, 0), 1'b1, 1'b0, 2'd0});
    check_eq("t3_wait_to_xfer", w, 2);
    put_exp(0, mk_data(0, 3, 1), 1'b0, 1'b0, 2'd0);
    fifo_if.free = 13'd2;
    set_req(0, 1'b1, mk_data(0, 3, 2), 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check_eq("t3_stall_ready", req0_if.ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_stall_wr", fifo_if.wr, 0);
    end
    @(posedge clk); #1;
    fifo_if.free = 13'd100;
    put_exp(0, mk_data(0, 3, 2), 1'b0, 1'b0, 2'd0);
    put_exp(0, mk_data(0, 3, 3), 1'b0, 1'b1, 2'd2);
    exp_frm++;

    // Abort after three words
    put_exp(1, mk_data(1, 4, 0), 1'b1, 1'b0, 2'd0);
    put_exp(1, mk_data(1, 4, 1), 1'b0, 1'b0, 2'd0);
    put_exp(1, mk_data(1, 4, 2), 1'b0, 1'b0, 2'd0);
    set_abort(1, 1'b1);
    @(negedge clk);
    check_eq("t4_abort_ready", req1_if.ready, 0);
    exp_abort++;
    @(posedge clk); #1;
    set_abort(1, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t4_abort_cnt", n_abort, exp_abort);
    check_eq("t4_frm_cnt", frm_cnt, exp_frm);
    @(posedge clk); #1;

    // Abort together with eof: abort wins
    put_exp(0, mk_data(0, 5, 0), 1'b1, 1'b0, 2'd0);
    put_exp(0, mk_data(0, 5, 1), 1'b0, 1'b0, 2'd0);
    set_req(0, 1'b1, mk_data(0, 5, 2), 1'b0, 1'b1, 2'd1);
    set_abort(0, 1'b1);
    @(negedge clk);
    check_eq("t4b_ready", req0_if.ready, 0);
    exp_abort++;
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    set_abort(0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t4b_abort_cnt", n_abort, exp_abort);
    check_eq("t4b_frm_cnt", frm_cnt, exp_frm);
    @(posedge clk); #1;

    // Oversize frame, then a normal frame
    send_frame(0, 6, 12, 2'd2);
    send_frame(1, 7, 4, 2'd1);
    repeat (2) @(negedge clk);
    check_eq("t5_err2", n_err[2], exp_err[2]);
    check_eq("t5_abort_cnt", n_abort, exp_abort);
    check_eq("t5_frm_cnt", frm_cnt, exp_frm);
    @(posedge clk); #1;

    // Reset in the middle of a frame
    put_exp(1, mk_data(1, 9, 0), 1'b1, 1'b0, 2'd0);
    put_exp(1, mk_data(1, 9, 1), 1'b0, 1'b0, 2'd0);
    set_req(1, 1'b1, mk_data(1, 9, 2), 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, 1'b0, 1'b0, 2'd0);
    exp_frm = 0;
    @(negedge clk);
    check_eq("t6_wr", fifo_if.wr, 0);
    check_eq("t6_abort", fifo_if.abort, 0);
    check_eq("t6_grant", grant, 0);
    check_eq("t6_frm_cnt", frm_cnt, exp_frm);
    check_eq("t6_err", err_pulse, 0);
    check_eq("t6_data", fifo_if.data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // sof inside a frame: rewind, protocol error, word restarts a new frame
    put_exp(0, mk_data(0, 10, 0), 1'b1, 1'b0, 2'd0);
    put_exp(0, mk_data(0, 10, 1), 1'b0, 1'b0, 2'd0);
    set_req(0, 1'b1, mk_data(0, 11, 0), 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    check_eq("t7_sof_ready", req0_if.ready, 0);
    exp_abort++;
    exp_err[1]++;
    send_frame(0, 11, 3, 2'd1);
    repeat (3) @(negedge clk);
    check_eq("t7_err1", n_err[1], exp_err[1]);
    check_eq("t7_frm_cnt", frm_cnt, exp_frm);

    // Totals
    check_eq("end_abort_cnt", n_abort, exp_abort);
    check_eq("end_err0", n_err[0], exp_err[0]);
    check_eq("end_err2", n_err[2], exp_err[2]);
    check_eq("end_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
